// File: rtl/scene_pkg.sv
// Shared scene constants and the game-state encoding used by the frame sequencer
// and the scene renderer.
package scene_pkg;

    localparam int unsigned SCROLL_WRAP   = 400;
    localparam int unsigned BAR_WIDTH     = 40;
    localparam int unsigned CENTER_BASE_Y = 290;
    localparam int unsigned DOT_X_POS     = 200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } game_state_e;

    // One bit per user button; used both for the raw pulses and the per-frame pending flags.
    typedef struct packed {
        logic pause;
        logic up;
        logic dn;
    } btn_evt_t;

endpackage

// File: rtl/scene_sequencer_if.sv
// Signal bundle between the VGA timing/button side and the scene sequencer.
interface scene_sequencer_if;

    logic       vsync;
    logic       btn_pause;
    logic       btn_up;
    logic       btn_dn;
    logic [9:0] target_y;

    logic       frame_tick;
    logic [9:0] x_offset;
    logic       game_started;
    logic       paused;
    logic [2:0] speed;
    logic [9:0] player_y;

    modport master (
        output vsync, btn_pause, btn_up, btn_dn, target_y,
        input  frame_tick, x_offset, game_started, paused, speed, player_y
    );

    modport slave (
        input  vsync, btn_pause, btn_up, btn_dn, target_y,
        output frame_tick, x_offset, game_started, paused, speed, player_y
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous push button followed by a registered
// rising-edge detector; emits a one-cycle pulse three clocks after the button rises.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // NOTE: every register here is state, so all assignments are non-blocking to keep
    // the pipeline stages from collapsing into one another within a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            pulse   <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-rate controller: derives a one-cycle frame tick from vsync, runs the
// IDLE/RUN/PAUSE game FSM, scrolls x_offset with wrap and slews player_y to its target.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int unsigned SCROLL_WRAP = scene_pkg::SCROLL_WRAP,
    parameter int unsigned START_DELAY = 30,
    parameter int unsigned SPEED_RST   = 4,
    parameter int unsigned SLEW        = 8,
    parameter int unsigned Y_RST       = 315
) (
    input logic               clk,
    input logic               reset,
    scene_sequencer_if.slave  bus
);

    localparam logic [1:0]  ST_IDLE    = IDLE;
    localparam logic [1:0]  ST_RUN     = RUN;
    localparam logic [1:0]  ST_PAUSE   = PAUSE;

    localparam logic [10:0] WRAP11     = 11'(SCROLL_WRAP);
    localparam logic [7:0]  START_CNT  = 8'(START_DELAY);
    localparam logic [2:0]  SPEED_INIT = 3'(SPEED_RST);
    localparam logic [9:0]  SLEW10     = 10'(SLEW);
    localparam logic [9:0]  Y_INIT     = 10'(Y_RST);

    logic [1:0]  state;
    logic        vsync_d;
    logic        frame_tick;
    logic [7:0]  frame_cnt;
    logic [9:0]  x_offset;
    logic [9:0]  player_y;
    logic [2:0]  speed;
    btn_evt_t    pulse;
    btn_evt_t    pend;

    logic [10:0] x_sum;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [2:0]  speed_next;

    btn_edge_sync u_sync_pause (.clk(clk), .reset(reset), .btn(bus.btn_pause), .pulse(pulse.pause));
    btn_edge_sync u_sync_up    (.clk(clk), .reset(reset), .btn(bus.btn_up),    .pulse(pulse.up));
    btn_edge_sync u_sync_dn    (.clk(clk), .reset(reset), .btn(bus.btn_dn),    .pulse(pulse.dn));

    // Sum is one bit wider than the offset so the wrap compare never overflows.
    always_comb begin
        x_sum  = {1'b0, x_offset} + {8'd0, speed};
        x_next = (x_sum >= WRAP11) ? 10'(x_sum - WRAP11) : x_sum[9:0];
    end

    // NOTE: each combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        y_next = player_y;
        if (bus.target_y > player_y) begin
            y_next = (bus.target_y - player_y > SLEW10) ? player_y + SLEW10 : bus.target_y;
        end else if (bus.target_y < player_y) begin
            y_next = (player_y - bus.target_y > SLEW10) ? player_y - SLEW10 : bus.target_y;
        end
    end

    // Simultaneous up and down presses cancel; the step saturates at 1 and 7.
    always_comb begin
        speed_next = speed;
        if (pend.up && !pend.dn && speed != 3'd7) begin
            speed_next = speed + 3'd1;
        end else if (pend.dn && !pend.up && speed != 3'd1) begin
            speed_next = speed - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
            x_offset   <= 10'd0;
            player_y   <= Y_INIT;
            speed      <= SPEED_INIT;
            pend       <= '0;
        end else begin
            vsync_d    <= bus.vsync;
            frame_tick <= bus.vsync & ~vsync_d;
            if (frame_tick) begin
                // A pulse landing on the tick cycle belongs to the next frame.
                pend <= pulse;
                case (state)
                    ST_IDLE: begin
                        frame_cnt <= frame_cnt + 8'd1;
                        player_y  <= bus.target_y;
                        if (frame_cnt + 8'd1 == START_CNT) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pend.pause) begin
                            state <= ST_PAUSE;
                        end else begin
                            x_offset <= x_next;
                            player_y <= y_next;
                        end
                        speed <= speed_next;
                    end
                    ST_PAUSE: begin
                        if (pend.pause) begin
                            state <= ST_RUN;
                        end
                        speed <= speed_next;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else begin
                pend <= btn_evt_t'(pend | pulse);
            end
        end
    end

    assign bus.frame_tick   = frame_tick;
    assign bus.x_offset     = x_offset;
    assign bus.game_started = (state != ST_IDLE);
    assign bus.paused       = (state == ST_PAUSE);
    assign bus.speed        = speed;
    assign bus.player_y     = player_y;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: a frame-level behavioural model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_scene_sequencer;

    localparam int WRAP        = 400;
    localparam int START_DELAY = 30;
    localparam int SPEED_RST   = 4;
    localparam int SLEW        = 8;
    localparam int Y_RST       = 315;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scene_sequencer_if sif ();

    scene_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_e;
    mstate_e m_st;
    int      m_cnt, m_x, m_y, m_speed;
    bit      m_tick, m_vprev;
    bit      m_pend [3];
    bit      m_bprev[3];
    int      due    [3][$];
    int      cyc = 0;
    bit      armed = 1'b0;

    function automatic void apply_tick(bit p_pause, bit p_up, bit p_dn, int tgt);
        mstate_e was = m_st;
        int diff;
        case (m_st)
            M_IDLE: begin
                m_cnt++;
                m_y = tgt;
                if (m_cnt == START_DELAY) m_st = M_RUN;
            end
            M_RUN: begin
                if (p_pause) begin
                    m_st = M_PAUSE;
                end else begin
                    m_x  = (m_x + m_speed) % WRAP;
                    diff = tgt - m_y;
                    if (diff > SLEW) diff = SLEW;
                    else if (diff < -SLEW) diff = -SLEW;
                    m_y += diff;
                end
            end
            default: if (p_pause) m_st = M_RUN;
        endcase
        if (was != M_IDLE && p_up != p_dn) begin
            if (p_up) m_speed = (m_speed >= 7) ? 7 : m_speed + 1;
            else      m_speed = (m_speed <= 1) ? 1 : m_speed - 1;
        end
    endfunction

    always @(posedge clk) begin
        bit btn[3];
        bit p[3];
        bit apply;
        btn[0] = sif.btn_pause;
        btn[1] = sif.btn_up;
        btn[2] = sif.btn_dn;
        cyc++;
        if (reset) begin
            m_st = M_IDLE; m_cnt = 0; m_x = 0; m_y = Y_RST; m_speed = SPEED_RST;
            m_tick = 1'b0; m_vprev = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_pend[b] = 1'b0; m_bprev[b] = 1'b0; due[b].delete();
            end
            armed = 1'b1;
        end else begin
            apply = m_tick;
            p     = m_pend;
            if (apply) begin
                apply_tick(p[0], p[1], p[2], int'(sif.target_y));
                for (int b = 0; b < 3; b++) m_pend[b] = 1'b0;
            end
            // A button rise reaches the pending flags three edges after it is first sampled.
            for (int b = 0; b < 3; b++) begin
                if (due[b].size() > 0 && due[b][0] == cyc) begin
                    m_pend[b] = 1'b1;
                    void'(due[b].pop_front());
                end
                if (btn[b] && !m_bprev[b]) due[b].push_back(cyc + 3);
                m_bprev[b] = btn[b];
            end
            m_tick  = sif.vsync && !m_vprev;
            m_vprev = sif.vsync;
        end
        if (armed) begin
            #1;
            check("frame_tick",   sif.frame_tick,   m_tick);
            check("x_offset",     sif.x_offset,     m_x);
            check("game_started", sif.game_started, m_st != M_IDLE);
            check("paused",       sif.paused,       m_st == M_PAUSE);
            check("speed",        sif.speed,        m_speed);
            check("player_y",     sif.player_y,     m_y);
        end
    end

    // ---------------- stimulus ----------------
    task automatic frame(input bit p, input bit u, input bit d, input int tgt);
        @(negedge clk);
        sif.target_y = 10'(tgt);
        sif.vsync    = 1'b1;
        repeat (2) @(negedge clk);
        sif.vsync = 1'b0;
        @(negedge clk);
        sif.btn_pause = p; sif.btn_up = u; sif.btn_dn = d;
        repeat (2) @(negedge clk);
        sif.btn_pause = 1'b0; sif.btn_up = 1'b0; sif.btn_dn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x_offset"},     sif.x_offset,     0);
        check({tag, "_speed"},        sif.speed,        SPEED_RST);
        check({tag, "_player_y"},     sif.player_y,     Y_RST);
        check({tag, "_game_started"}, sif.game_started, 0);
        check({tag, "_paused"},       sif.paused,       0);
        check({tag, "_frame_tick"},   sif.frame_tick,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_up[6];
        reset = 1'b1;
        sif.vsync = 1'b0; sif.btn_pause = 1'b0; sif.btn_up = 1'b0; sif.btn_dn = 1'b0;
        sif.target_y = 10'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        // Start-up delay: nothing moves before the 30th tick.
        for (int i = 1; i <= 29; i++) begin
            frame(1'b0, 1'b0, 1'b0, 340);
            check("idle_game_started", sif.game_started, 0);
        end
        frame(1'b0, 1'b0, 1'b0, 340);
        check("t30_game_started", sif.game_started, 1);
        check("t30_x_offset",     sif.x_offset,     0);
        check("t30_player_y",     sif.player_y,     340);

        // Slew down from 340 to 300 in steps of 8, then a short 3-pixel step.
        for (int i = 1; i <= 5; i++) begin
            frame(1'b0, 1'b0, 1'b0, 300);
            check("run_x_offset", sif.x_offset, 4 * i);
            check("slew_y",       sif.player_y, 340 - 8 * i);
        end
        frame(1'b0, 1'b0, 1'b0, 303);
        check("slew_small_y", sif.player_y, 303);

        for (int i = 37; i <= 129; i++) frame(1'b0, 1'b0, 1'b0, 303);
        check("pre_wrap_x", sif.x_offset, 396);
        frame(1'b0, 1'b0, 1'b0, 303);
        check("wrap_x", sif.x_offset, 0);

        // Pause toggle: pressed in one frame, takes effect at the next tick.
        frame(1'b1, 1'b0, 1'b0, 303);
        check("pz_press_x", sif.x_offset, 4);
        check("pz_press_p", sif.paused,   0);
        frame(1'b0, 1'b0, 1'b0, 303);
        check("pz_on_p", sif.paused,   1);
        check("pz_on_x", sif.x_offset, 4);
        frame(1'b1, 1'b0, 1'b0, 303);
        check("pz_hold_x", sif.x_offset, 4);
        frame(1'b0, 1'b0, 1'b0, 303);
        check("pz_off_p", sif.paused,   0);
        check("pz_off_x", sif.x_offset, 4);
        frame(1'b0, 1'b0, 1'b0, 303);
        check("pz_resume_x", sif.x_offset, 8);

        // Speed up to saturation, cancel, then down to saturation.
        exp_up = '{4, 5, 6, 7, 7, 7};
        for (int k = 0; k < 6; k++) begin
            frame(1'b0, k < 5, 1'b0, 303);
            check("speed_up", sif.speed, exp_up[k]);
        end
        frame(1'b0, 1'b1, 1'b1, 303);
        frame(1'b0, 1'b0, 1'b0, 303);
        check("speed_cancel", sif.speed, 7);
        for (int k = 0; k < 8; k++) begin
            frame(1'b0, 1'b0, k < 7, 303);
            check("speed_dn", sif.speed, (7 - k < 1) ? 1 : 7 - k);
        end

        // Reset mid-RUN with a pause pending.
        @(negedge clk);
        sif.btn_pause = 1'b1;
        repeat (2) @(negedge clk);
        sif.btn_pause = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midrst");
        for (int i = 1; i <= 30; i++) frame(1'b0, 1'b0, 1'b0, 315);
        check("midrst_started", sif.game_started, 1);
        check("midrst_paused",  sif.paused,       0);
        frame(1'b0, 1'b0, 1'b0, 315);
        check("midrst_paused2", sif.paused,   0);
        check("midrst_x",       sif.x_offset, 4);

        // Randomized frames: varying lengths, button activity and targets, rare resets.
        for (int f = 0; f < 400; f++) begin
            int hi  = $urandom_range(1, 3);
            int len = hi + $urandom_range(1, 12);
            int rst_at = ($urandom_range(0, 99) == 0) ? $urandom_range(0, len - 1) : -1;
            sif.target_y = 10'($urandom_range(0, 1023));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                sif.vsync = (c < hi);
                if ($urandom_range(0, 5) == 0) sif.btn_pause = ~sif.btn_pause;
                if ($urandom_range(0, 3) == 0) sif.btn_up    = ~sif.btn_up;
                if ($urandom_range(0, 4) == 0) sif.btn_dn    = ~sif.btn_dn;
                reset = (c == rst_at);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        sif.vsync = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
